// File: rtl/mode_cmd_pkg.sv
// Shared constants, frame bytes, response codes and FSM encoding for the mode command decoder.
// Build option MODE_CMD_CHECKSUM_EN adds a trailing checksum byte (and its wait state) to each frame.
package mode_cmd_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [7:0] HDR_BYTE     = 8'hA5;
  localparam logic [7:0] OP_SET_MODE  = 8'h01;
  localparam logic [7:0] OP_GET_MODE  = 8'h02;
  localparam logic [7:0] RSP_ACK      = 8'h06;
  localparam logic [7:0] RSP_NAK      = 8'h15;
  localparam logic [7:0] RSP_GET_BASE = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_OK,
    S_GOT_OP,
`ifdef MODE_CMD_CHECKSUM_EN
    S_CHK,
`endif
    S_EXEC,
    S_SETUP,
    S_PULSE,
    S_RESP
  } state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] arg);
    return op ^ arg ^ HDR_BYTE;
  endfunction

endpackage

// File: rtl/mode_cmd_decoder_gap_timer.sv
// Idle-gap counter: counts cycles while enabled and flags expiry on the last allowed idle cycle,
// so the owner can leave its state on the following edge.
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mode_cmd_decoder.sv
// Framed SET_MODE/GET_MODE decoder driving the mode selector's mode_input/select pair with a stretched strobe.
// Define MODE_CMD_CHECKSUM_EN to require a CHK byte (OP ^ ARG ^ 0xA5) after ARG.
module mode_cmd_decoder
  import mode_cmd_pkg::*;
#(
  parameter int unsigned SELECT_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [MODE_W-1:0] mode_input,
  output logic              select,
  output logic [MODE_W-1:0] cur_mode,
  output logic              busy,
  output logic [7:0]        err_count
);

  state_e            state_q;
  state_e            state_d;
  logic [7:0]        op_q;
  logic [7:0]        arg_q;
  logic [7:0]        pulse_cnt_q;
  logic [MODE_W-1:0] mode_input_q;
  logic [MODE_W-1:0] cur_mode_q;
  logic              select_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [7:0]        err_count_q;

  logic       rx_fire;
  logic       collecting;
  logic       tmo_expired;
  logic       chk_ok;
  logic       exec_set;
  logic       exec_get;
  logic [7:0] rsp_d;

`ifdef MODE_CMD_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= '0;
    end else if (rx_fire && state_q == S_CHK) begin
      chk_q <= rx_data;
    end
  end

  assign chk_ok = (chk_q == frame_chk(op_q, arg_q));
`else
  assign chk_ok = 1'b1;
`endif

  assign rx_fire  = rx_valid && rx_ready;
  assign exec_set = chk_ok && (op_q == OP_SET_MODE) && (arg_q[7:MODE_W] == '0);
  assign exec_get = chk_ok && (op_q == OP_GET_MODE);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_fire || !collecting),
    .enable (collecting && !rx_fire),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fire && rx_data == HDR_BYTE) state_d = S_HDR_OK;
      end
      S_HDR_OK: begin
        if (tmo_expired)  state_d = S_IDLE;
        else if (rx_fire) state_d = S_GOT_OP;
      end
      S_GOT_OP: begin
        if (tmo_expired) begin
          state_d = S_IDLE;
        end else if (rx_fire) begin
`ifdef MODE_CMD_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_EXEC;
`endif
        end
      end
`ifdef MODE_CMD_CHECKSUM_EN
      S_CHK: begin
        if (tmo_expired)  state_d = S_IDLE;
        else if (rx_fire) state_d = S_EXEC;
      end
`endif
      S_EXEC:  state_d = exec_set ? S_SETUP : S_RESP;
      S_SETUP: state_d = S_PULSE;
      S_PULSE: begin
        if (pulse_cnt_q == 8'(SELECT_WIDTH - 1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = 1'b0;
    collecting = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: rx_ready = 1'b1;
      S_HDR_OK, S_GOT_OP: begin
        rx_ready   = 1'b1;
        collecting = 1'b1;
      end
`ifdef MODE_CMD_CHECKSUM_EN
      S_CHK: begin
        rx_ready   = 1'b1;
        collecting = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Response byte is chosen on entry to RESP and then held for the whole handshake.
  always_comb begin
    rsp_d = RSP_NAK;
    if (state_q == S_PULSE)  rsp_d = RSP_ACK;
    else if (exec_get)       rsp_d = RSP_GET_BASE | {{(8 - MODE_W){1'b0}}, cur_mode_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      arg_q        <= '0;
      pulse_cnt_q  <= '0;
      mode_input_q <= '0;
      cur_mode_q   <= '0;
      select_q     <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      if (rx_fire && state_q == S_HDR_OK) op_q  <= rx_data;
      if (rx_fire && state_q == S_GOT_OP) arg_q <= rx_data;
      // mode_input moves only on EXEC->SETUP, a full cycle before select rises.
      if (state_q == S_EXEC && exec_set) mode_input_q <= arg_q[MODE_W-1:0];
      select_q    <= (state_d == S_PULSE);
      pulse_cnt_q <= (state_q == S_PULSE) ? pulse_cnt_q + 8'd1 : 8'd0;
      if (state_q == S_PULSE && state_d == S_RESP) cur_mode_q <= mode_input_q;
      tx_valid_q <= (state_d == S_RESP);
      if (state_d == S_RESP && state_q != S_RESP) tx_data_q <= rsp_d;
      if (((state_q == S_EXEC && !exec_set && !exec_get) || tmo_expired) && err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign mode_input = mode_input_q;
  assign select     = select_q;
  assign cur_mode   = cur_mode_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_mode_cmd_decoder.sv
// Directed self-checking bench for mode_cmd_decoder (SELECT_WIDTH=4, TIMEOUT_CYCLES=16); works with or without MODE_CMD_CHECKSUM_EN.
module tb_mode_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] mode_input;
  logic       select;
  logic [1:0] cur_mode;
  logic       busy;
  logic [7:0] err_count;

  int compared   = 0;
  int mismatched = 0;
  int exp_err    = 0;

  mode_cmd_decoder #(
    .SELECT_WIDTH  (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mode_input(mode_input),
    .select    (select),
    .cur_mode  (cur_mode),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      compared++; mismatched++;
      $display("FAIL send_byte_wait: rx_ready=%b never 1 for byte %02h", rx_ready, b);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] arg);
    logic [7:0] chk;
    chk = 8'hA5 ^ op ^ arg;
`ifdef MODE_CMD_CHECKSUM_EN
    $display("frame: A5 %02h %02h %02h", op, arg, chk);
`else
    $display("frame: A5 %02h %02h", op, arg);
`endif
    send_byte(8'hA5);
    send_byte(op);
    send_byte(arg);
`ifdef MODE_CMD_CHECKSUM_EN
    send_byte(chk);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    compared++; if (mode_input !== 2'd0) begin mismatched++; $display("FAIL rst_mode_input: got %0d want 0", mode_input); end
    compared++; if (select !== 1'b0) begin mismatched++; $display("FAIL rst_select: got %b want 0", select); end
    compared++; if (cur_mode !== 2'd0) begin mismatched++; $display("FAIL rst_cur_mode: got %0d want 0", cur_mode); end
    compared++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_tx: got v=%b d=%02h want v=0 d=00", tx_valid, tx_data); end
    compared++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin mismatched++; $display("FAIL rst_busy_ready: got busy=%b rdy=%b want 0/1", busy, rx_ready); end
    compared++; if (err_count !== 8'd0) begin mismatched++; $display("FAIL rst_err: got %0d want 0", err_count); end
  endtask

  task automatic test_set();
    tx_ready = 1'b1;
    send_frame(8'h01, 8'h02);
    // T+1: EXEC
    compared++; if (busy !== 1'b1 || rx_ready !== 1'b0 || mode_input !== 2'd0) begin mismatched++; $display("FAIL set_exec: got busy=%b rdy=%b mi=%0d want 1/0/0", busy, rx_ready, mode_input); end
    tick();
    // T+2: SETUP
    compared++; if (mode_input !== 2'd2 || select !== 1'b0) begin mismatched++; $display("FAIL set_setup: got mi=%0d sel=%b want 2/0", mode_input, select); end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++; if (select !== 1'b1 || mode_input !== 2'd2 || tx_valid !== 1'b0) begin mismatched++; $display("FAIL set_pulse_%0d: got sel=%b mi=%0d txv=%b want 1/2/0", i, select, mode_input, tx_valid); end
    end
    tick();
    compared++; if (select !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h06 || cur_mode !== 2'd2) begin mismatched++; $display("FAIL set_ack: got sel=%b txv=%b txd=%02h cm=%0d want 0/1/06/2", select, tx_valid, tx_data, cur_mode); end
    tick();
    compared++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0 || mode_input !== 2'd2) begin mismatched++; $display("FAIL set_done: got txv=%b rdy=%b busy=%b mi=%0d want 0/1/0/2", tx_valid, rx_ready, busy, mode_input); end
  endtask

  task automatic test_get();
    send_frame(8'h02, 8'h00);
    compared++; if (select !== 1'b0 || tx_valid !== 1'b0) begin mismatched++; $display("FAIL get_exec: got sel=%b txv=%b want 0/0", select, tx_valid); end
    tick();
    compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h42 || select !== 1'b0) begin mismatched++; $display("FAIL get_resp: got txv=%b txd=%02h sel=%b want 1/42/0", tx_valid, tx_data, select); end
    tick();
    compared++; if (tx_valid !== 1'b0 || busy !== 1'b0 || cur_mode !== 2'd2 || mode_input !== 2'd2 || err_count !== 8'd0) begin mismatched++; $display("FAIL get_after: got txv=%b busy=%b cm=%0d mi=%0d err=%0d want 0/0/2/2/0", tx_valid, busy, cur_mode, mode_input, err_count); end
  endtask

  task automatic test_nak();
    send_frame(8'h01, 8'h05);
    tick();
    compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin mismatched++; $display("FAIL nak_reserved: got txv=%b txd=%02h want 1/15", tx_valid, tx_data); end
    exp_err++;
    tick();
    send_frame(8'h07, 8'h00);
    tick();
    compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin mismatched++; $display("FAIL nak_opcode: got txv=%b txd=%02h want 1/15", tx_valid, tx_data); end
    exp_err++;
    tick();
`ifdef MODE_CMD_CHECKSUM_EN
    $display("frame: A5 01 02 00 (bad chk)");
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    tick();
    compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin mismatched++; $display("FAIL nak_chk: got txv=%b txd=%02h want 1/15", tx_valid, tx_data); end
    exp_err++;
    tick();
`endif
    compared++; if (err_count !== 8'(exp_err) || mode_input !== 2'd2 || cur_mode !== 2'd2) begin mismatched++; $display("FAIL nak_state: got err=%0d mi=%0d cm=%0d want %0d/2/2", err_count, mode_input, cur_mode, exp_err); end
  endtask

  task automatic test_timeout();
    int n = 0;
    $display("partial frame: A5 01 then idle");
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int k = 1; k < 16; k++) begin
      tick();
    end
    compared++; if (busy !== 1'b1 || tx_valid !== 1'b0) begin mismatched++; $display("FAIL tmo_before: got busy=%b txv=%b want 1/0", busy, tx_valid); end
    tick();
    exp_err++;
    compared++; if (busy !== 1'b0 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL tmo_expire: got busy=%b rdy=%b txv=%b err=%0d want 0/1/0/%0d", busy, rx_ready, tx_valid, err_count, exp_err); end
    send_frame(8'h01, 8'h01);
    while (tx_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h06 || cur_mode !== 2'd1 || mode_input !== 2'd1) begin mismatched++; $display("FAIL tmo_recover: got txv=%b txd=%02h cm=%0d mi=%0d want 1/06/1/1", tx_valid, tx_data, cur_mode, mode_input); end
    tick();
  endtask

  task automatic test_back_pressure();
    tx_ready = 1'b0;
    send_frame(8'h01, 8'h03);
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h06 || rx_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold_%0d: got txv=%b txd=%02h rdy=%b want 1/06/0", i, tx_valid, tx_data, rx_ready); end
      tick();
    end
    tx_ready = 1'b1;
    tick();
    compared++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0 || cur_mode !== 2'd3) begin mismatched++; $display("FAIL bp_release: got txv=%b rdy=%b busy=%b cm=%0d want 0/1/0/3", tx_valid, rx_ready, busy, cur_mode); end
  endtask

  task automatic test_reset_mid_pulse();
    send_frame(8'h01, 8'h01);
    tick();
    tick();
    tick();
    compared++; if (select !== 1'b1 || mode_input !== 2'd1) begin mismatched++; $display("FAIL rmp_pulse2: got sel=%b mi=%0d want 1/1", select, mode_input); end
    reset = 1'b1;
    tick();
    compared++; if (select !== 1'b0 || mode_input !== 2'd0 || cur_mode !== 2'd0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin mismatched++; $display("FAIL rmp_outputs: got sel=%b mi=%0d cm=%0d txv=%b txd=%02h want 0/0/0/0/00", select, mode_input, cur_mode, tx_valid, tx_data); end
    compared++; if (busy !== 1'b0 || rx_ready !== 1'b1 || err_count !== 8'd0) begin mismatched++; $display("FAIL rmp_status: got busy=%b rdy=%b err=%0d want 0/1/0", busy, rx_ready, err_count); end
    reset = 1'b0;
    $display("stray bytes: 11 22");
    send_byte(8'h11);
    send_byte(8'h22);
    compared++; if (busy !== 1'b0 || err_count !== 8'd0) begin mismatched++; $display("FAIL stray_discard: got busy=%b err=%0d want 0/0", busy, err_count); end
    send_frame(8'h02, 8'h00);
    tick();
    compared++; if (tx_valid !== 1'b1 || tx_data !== 8'h40) begin mismatched++; $display("FAIL stray_get: got txv=%b txd=%02h want 1/40", tx_valid, tx_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_set();
    test_get();
    test_nak();
    test_timeout();
    test_back_pressure();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
